// File: rtl/mem_stage_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_unit
//
// Memory-stage engine of a 5-stage RISC-V pipeline. It takes the EX/MEM
// register contents and either passes them straight into MEM/WB (ALU ops) or
// issues one data-memory access over a req/ready handshake, stalling the
// upstream stages until that access completes or times out. It also resolves
// conditional branches (branch & zero).
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   *_in                  EX/MEM payload (control, ALU result/address, store
//                         data, destination register, branch target, zero flag)
//   dmem_req/we/addr/wdata  registered request to data memory
//   dmem_ready/rdata      completion strobe and load data from data memory
//   stall                 hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   pc_src, branch_target branch-taken redirect (combinational)
//   wb_*                  registered MEM/WB payload
//   mem_err               sticky error: misaligned, read+write conflict, timeout
// -----------------------------------------------------------------------------
module mem_stage_unit #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_to_reg_in,
    input  logic            reg_write_en_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            branch_in,
    input  logic [XLEN-1:0] pc_next_in,
    input  logic            z_flag_in,
    input  logic [XLEN-1:0] alu_out_in,
    input  logic [XLEN-1:0] data_in,
    input  logic [4:0]      rd_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic            pc_src,
    output logic [XLEN-1:0] branch_target,
    output logic            wb_mem_to_reg,
    output logic            wb_reg_write_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_alu_out,
    output logic [XLEN-1:0] wb_read_data,
    output logic            mem_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [4:0]        p_rd_q, p_rd_d;
    logic              p_m2r_q, p_m2r_d;
    logic              p_rw_q, p_rw_d;
    logic              wb_m2r_q, wb_m2r_d;
    logic              wb_rw_q, wb_rw_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_alu_q, wb_alu_d;
    logic [XLEN-1:0]   wb_rdata_q, wb_rdata_d;
    logic              err_q, err_d;

    logic              access_s;
    logic              legal_s;
    logic              timeout_s;

    assign access_s  = mem_read_in | mem_write_in;
    // Accesses are doubleword-aligned only, and a single op may not both load and store.
    assign legal_s   = (alu_out_in[2:0] == 3'b000) & ~(mem_read_in & mem_write_in);
    assign timeout_s = (cnt_q >= TIMEOUT_LIM);

    // Stall while launching, and while waiting with budget left; the completing
    // or aborting cycle releases upstream so it advances on that same edge.
    assign stall = ((state_q == ST_IDLE) & access_s & legal_s) |
                   ((state_q == ST_ACCESS) & ~dmem_ready & ~timeout_s);

    assign pc_src        = branch_in & z_flag_in & (state_q == ST_IDLE);
    assign branch_target = pc_next_in;

    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = wdata_q;
    assign wb_mem_to_reg   = wb_m2r_q;
    assign wb_reg_write_en = wb_rw_q;
    assign wb_rd           = wb_rd_q;
    assign wb_alu_out      = wb_alu_q;
    assign wb_read_data    = wb_rdata_q;
    assign mem_err         = err_q;

    // Next-state, request and MEM/WB payload selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        p_rd_d     = p_rd_q;
        p_m2r_d    = p_m2r_q;
        p_rw_d     = p_rw_q;
        wb_m2r_d   = wb_m2r_q;
        wb_rw_d    = wb_rw_q;
        wb_rd_d    = wb_rd_q;
        wb_alu_d   = wb_alu_q;
        wb_rdata_d = wb_rdata_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (access_s) begin
                    // Any access puts a bubble into MEM/WB this cycle.
                    wb_m2r_d   = 1'b0;
                    wb_rw_d    = 1'b0;
                    wb_rd_d    = 5'd0;
                    wb_alu_d   = {XLEN{1'b0}};
                    wb_rdata_d = {XLEN{1'b0}};
                    if (legal_s) begin
                        // addr_q doubles as the pending ALU result for writeback.
                        addr_d  = alu_out_in;
                        wdata_d = data_in;
                        we_d    = mem_write_in;
                        p_rd_d  = rd_in;
                        p_m2r_d = mem_to_reg_in;
                        p_rw_d  = reg_write_en_in;
                        req_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = ST_ACCESS;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    wb_m2r_d   = mem_to_reg_in;
                    wb_rw_d    = reg_write_en_in;
                    wb_rd_d    = rd_in;
                    wb_alu_d   = alu_out_in;
                    wb_rdata_d = {XLEN{1'b0}};
                end
            end
            ST_ACCESS: begin
                if (dmem_ready) begin
                    wb_m2r_d   = p_m2r_q;
                    wb_rw_d    = p_rw_q;
                    wb_rd_d    = p_rd_q;
                    wb_alu_d   = addr_q;
                    wb_rdata_d = we_q ? {XLEN{1'b0}} : dmem_rdata;
                    req_d      = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = ST_IDLE;
                end else if (timeout_s) begin
                    wb_m2r_d   = 1'b0;
                    wb_rw_d    = 1'b0;
                    wb_rd_d    = 5'd0;
                    wb_alu_d   = {XLEN{1'b0}};
                    wb_rdata_d = {XLEN{1'b0}};
                    err_d      = 1'b1;
                    req_d      = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                req_d   = 1'b0;
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request and MEM/WB registers; reset drops the request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {XLEN{1'b0}};
            wdata_q    <= {XLEN{1'b0}};
            p_rd_q     <= 5'd0;
            p_m2r_q    <= 1'b0;
            p_rw_q     <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_alu_q   <= {XLEN{1'b0}};
            wb_rdata_q <= {XLEN{1'b0}};
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            p_rd_q     <= p_rd_d;
            p_m2r_q    <= p_m2r_d;
            p_rw_q     <= p_rw_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            wb_rd_q    <= wb_rd_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_unit
//
// Directed and randomized bench for mem_stage_unit. Each operation is issued
// at transaction level; the expected per-cycle stall/request behaviour and the
// MEM/WB result are derived from the operation kind, its address and the
// memory latency chosen by the bench (cycles of ready=0 before ready=1).
// -----------------------------------------------------------------------------
module tb_mem_stage_unit;

    localparam int XLEN = 64;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            mem_to_reg_in, reg_write_en_in, mem_read_in, mem_write_in;
    logic            branch_in, z_flag_in;
    logic [XLEN-1:0] pc_next_in, alu_out_in, data_in;
    logic [4:0]      rd_in;
    logic            dmem_req, dmem_we, dmem_ready;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            stall, pc_src;
    logic [XLEN-1:0] branch_target;
    logic            wb_mem_to_reg, wb_reg_write_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_alu_out, wb_read_data;
    logic            mem_err;

    int   vecs    = 0;
    int   errs    = 0;
    logic err_exp = 1'b0;

    always #5 clk = ~clk;

    mem_stage_unit #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_en_in(reg_write_en_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .branch_in(branch_in), .pc_next_in(pc_next_in), .z_flag_in(z_flag_in),
        .alu_out_in(alu_out_in), .data_in(data_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write_en(wb_reg_write_en),
        .wb_rd(wb_rd), .wb_alu_out(wb_alu_out), .wb_read_data(wb_read_data),
        .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        mem_to_reg_in = 1'b0; reg_write_en_in = 1'b0;
        mem_read_in = 1'b0;   mem_write_in = 1'b0;
        branch_in = 1'b0;     z_flag_in = 1'b0;
        pc_next_in = 64'd0;   alu_out_in = 64'd0;
        data_in = 64'd0;      rd_in = 5'd0;
    endtask

    task automatic chk_wb_bubble(input string tag);
        chk({tag, "_wb_rw"},  {63'd0, wb_reg_write_en}, 64'd0);
        chk({tag, "_wb_m2r"}, {63'd0, wb_mem_to_reg}, 64'd0);
        chk({tag, "_wb_rd"},  {59'd0, wb_rd}, 64'd0);
        chk({tag, "_wb_alu"}, wb_alu_out, 64'd0);
        chk({tag, "_wb_rdat"}, wb_read_data, 64'd0);
    endtask

    // Non-memory op: one-cycle passthrough into MEM/WB, never stalls.
    task automatic alu_op(input logic [4:0] rd, input logic [63:0] alu, input logic rw,
                          input logic m2r, input logic br, input logic z, input logic [63:0] pcn);
        clear_ex();
        rd_in = rd; alu_out_in = alu; reg_write_en_in = rw; mem_to_reg_in = m2r;
        branch_in = br; z_flag_in = z; pc_next_in = pcn; data_in = rnd64();
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = rnd64();
        #1;
        chk("alu_stall", {63'd0, stall}, 64'd0);
        chk("alu_pc_src", {63'd0, pc_src}, {63'd0, br & z});
        chk("alu_btarget", branch_target, pcn);
        tick();
        chk("alu_wb_rd", {59'd0, wb_rd}, {59'd0, rd});
        chk("alu_wb_alu", wb_alu_out, alu);
        chk("alu_wb_rw", {63'd0, wb_reg_write_en}, {63'd0, rw});
        chk("alu_wb_m2r", {63'd0, wb_mem_to_reg}, {63'd0, m2r});
        chk("alu_wb_rdat", wb_read_data, 64'd0);
        chk("alu_req", {63'd0, dmem_req}, 64'd0);
        chk("alu_err", {63'd0, mem_err}, {63'd0, err_exp});
    endtask

    // Memory op; lat = number of ACCESS cycles with ready low before ready rises.
    // If lat exceeds TO the access aborts in ACCESS cycle index TO.
    task automatic mem_op(input logic rd_op, input logic wr_op, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [4:0] rd, input logic rw,
                          input logic m2r, input int lat, input logic [63:0] rdat);
        logic legal;
        logic tmo;
        int   n;
        legal = (addr[2:0] == 3'b000) && !(rd_op && wr_op);
        tmo   = (lat > TO);
        n     = (lat < TO) ? lat : TO;
        clear_ex();
        mem_read_in = rd_op; mem_write_in = wr_op; alu_out_in = addr; data_in = wd;
        rd_in = rd; reg_write_en_in = rw; mem_to_reg_in = m2r;
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = rnd64();
        #1;
        chk("mem_launch_stall", {63'd0, stall}, {63'd0, legal});
        chk("mem_launch_pc_src", {63'd0, pc_src}, 64'd0);
        tick();
        if (!legal) begin
            err_exp = 1'b1;
            chk("ill_req", {63'd0, dmem_req}, 64'd0);
            chk("ill_err", {63'd0, mem_err}, 64'd1);
            chk_wb_bubble("ill");
            return;
        end
        chk("acc_req", {63'd0, dmem_req}, 64'd1);
        chk("acc_addr", dmem_addr, addr);
        chk("acc_we", {63'd0, dmem_we}, {63'd0, wr_op});
        chk("acc_wdata", dmem_wdata, wd);
        chk_wb_bubble("acc");
        for (int c = 0; c < n; c++) begin
            dmem_ready = 1'b0;
            dmem_rdata = rnd64();
            branch_in  = 1'($urandom_range(0, 1));
            z_flag_in  = 1'($urandom_range(0, 1));
            #1;
            chk("wait_stall", {63'd0, stall}, 64'd1);
            chk("wait_pc_src", {63'd0, pc_src}, 64'd0);
            tick();
            chk("wait_req", {63'd0, dmem_req}, 64'd1);
            chk("wait_addr", dmem_addr, addr);
            chk("wait_wdata", dmem_wdata, wd);
            chk("wait_we", {63'd0, dmem_we}, {63'd0, wr_op});
            chk("wait_wb_rw", {63'd0, wb_reg_write_en}, 64'd0);
        end
        dmem_ready = !tmo;
        dmem_rdata = rdat;
        #1;
        chk("end_stall", {63'd0, stall}, 64'd0);
        tick();
        dmem_ready = 1'b0;
        chk("end_req", {63'd0, dmem_req}, 64'd0);
        if (tmo) begin
            err_exp = 1'b1;
            chk("tmo_err", {63'd0, mem_err}, 64'd1);
            chk_wb_bubble("tmo");
        end else begin
            chk("done_wb_rd", {59'd0, wb_rd}, {59'd0, rd});
            chk("done_wb_rw", {63'd0, wb_reg_write_en}, {63'd0, rw});
            chk("done_wb_m2r", {63'd0, wb_mem_to_reg}, {63'd0, m2r});
            chk("done_wb_alu", wb_alu_out, addr);
            chk("done_wb_rdat", wb_read_data, rd_op ? rdat : 64'd0);
            chk("done_err", {63'd0, mem_err}, {63'd0, err_exp});
        end
    endtask

    initial begin
        int kind;
        logic [63:0] a;
        reset = 1'b1;
        clear_ex();
        dmem_ready = 1'b0;
        dmem_rdata = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_we", {63'd0, dmem_we}, 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_wdata", dmem_wdata, 64'd0);
        chk("rst_err", {63'd0, mem_err}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk_wb_bubble("rst");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Directed scenarios
        alu_op(5'd5, 64'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        mem_op(1'b1, 1'b0, 64'h100, 64'd0, 5'd7, 1'b1, 1'b1, 3, 64'hDEADBEEF);
        mem_op(1'b0, 1'b1, 64'h08, 64'hA5, 5'd0, 1'b0, 1'b0, 0, 64'd0);
        mem_op(1'b1, 1'b0, 64'h104, 64'd0, 5'd9, 1'b1, 1'b1, 0, 64'd0);
        mem_op(1'b1, 1'b0, 64'h110, 64'd0, 5'd9, 1'b1, 1'b1, 1, 64'h0123_4567_89AB_CDEF);
        mem_op(1'b1, 1'b1, 64'h200, 64'h55, 5'd3, 1'b1, 1'b1, 0, 64'd0);
        mem_op(1'b1, 1'b0, 64'h300, 64'd0, 5'd4, 1'b1, 1'b1, 100, 64'd0);
        mem_op(1'b1, 1'b0, 64'h308, 64'd0, 5'd4, 1'b1, 1'b1, TO, 64'hCAFE);
        alu_op(5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h400);
        alu_op(5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h400);

        // Reset in the middle of an outstanding access
        clear_ex();
        mem_read_in = 1'b1; alu_out_in = 64'h500; rd_in = 5'd6; reg_write_en_in = 1'b1;
        dmem_ready = 1'b0;
        tick();
        chk("mid_req_before", {63'd0, dmem_req}, 64'd1);
        tick();
        reset = 1'b1;
        clear_ex();
        #1;
        err_exp = 1'b0;
        chk("mid_rst_req", {63'd0, dmem_req}, 64'd0);
        chk("mid_rst_err", {63'd0, mem_err}, 64'd0);
        chk("mid_rst_stall", {63'd0, stall}, 64'd0);
        chk_wb_bubble("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        tick();
        mem_op(1'b1, 1'b0, 64'h600, 64'd0, 5'd11, 1'b1, 1'b1, 2, 64'h7777);

        // Randomized mix
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 3));
            a = rnd64() & ~64'h7;
            case (kind)
                0: alu_op(5'($urandom()), rnd64(), 1'($urandom()), 1'($urandom()),
                          1'($urandom()), 1'($urandom()), rnd64());
                1: mem_op(1'b1, 1'b0, a, rnd64(), 5'($urandom()), 1'($urandom()),
                          1'($urandom()), int'($urandom_range(0, TO + 2)), rnd64());
                2: mem_op(1'b0, 1'b1, a, rnd64(), 5'($urandom()), 1'($urandom()),
                          1'($urandom()), int'($urandom_range(0, TO + 2)), rnd64());
                default: mem_op(1'b1, 1'($urandom()), a | 64'($urandom_range(0, 7)),
                                rnd64(), 5'($urandom()), 1'b1, 1'b1,
                                int'($urandom_range(0, 2)), rnd64());
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
